// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: a first-word fall-through FIFO between the fetch
// unit and the instruction register. Branch flush discards all contents, and a
// sticky overflow flag records any word offered while the queue was full.
module instr_prefetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage; never cleared, since out_data masks everything outside the live window
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic in_ready_s;
    logic out_valid_s;
    logic push_s;
    logic pop_s;
    logic drop_s;

    // Handshake qualifiers decoded from registered state; flush overrides both transfers
    always_comb begin
        in_ready_s  = (count_q != FULL_CNT);
        out_valid_s = (count_q != {CNT_W{1'b0}});
        push_s      = in_valid && in_ready_s && !flush;
        pop_s       = out_valid_s && out_ready && !flush;
        drop_s      = in_valid && !in_ready_s && !flush;
    end

    // Next-state computation for pointers, occupancy and the sticky overflow flag
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            if (push_s) begin
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + AW'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Write the accepted word at the tail slot
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[tail_q] <= in_data;
        end
    end

    // Output decode: head word falls through, forced to zero when the queue is empty
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_s;
        count     = count_q;
        ovf       = ovf_q;
        if (out_valid_s) begin
            out_data = mem_q[head_q];
        end else begin
            out_data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_instr_prefetch_queue;

    logic CLK;
    logic CLR;

    // DEPTH=4, DATA_W=32 instance
    logic        a_in_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data;
    logic        a_in_ready, a_out_valid, a_ovf;
    logic [31:0] a_out_data;
    logic [2:0]  a_count;

    // DEPTH=8, DATA_W=16 instance
    logic        b_in_valid, b_out_ready, b_flush;
    logic [15:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [15:0] b_out_data;
    logic [3:0]  b_count;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues plus sticky flag
    logic [31:0] mq[$];
    bit          movf;
    logic [15:0] bq[$];
    bit          bovf;

    logic [31:0] w [4];

    instr_prefetch_queue #(.DATA_W(32), .DEPTH(4), .CNT_W(3)) dut_a (
        .CLK(CLK), .CLR(CLR),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .flush(a_flush), .count(a_count), .ovf(a_ovf)
    );

    instr_prefetch_queue #(.DATA_W(16), .DEPTH(8), .CNT_W(4)) dut_b (
        .CLK(CLK), .CLR(CLR),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .flush(b_flush), .count(b_count), .ovf(b_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance both models by one edge using the currently driven inputs, then
    // move to 1 time unit after the edge.
    task automatic step();
        int sa = mq.size();
        int sb = bq.size();
        if (a_flush) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (a_in_valid && sa == 4) movf = 1'b1;
            if (a_out_ready && sa != 0) void'(mq.pop_front());
            if (a_in_valid && sa != 4) mq.push_back(a_in_data);
        end
        if (b_flush) begin
            bq.delete();
            bovf = 1'b0;
        end else begin
            if (b_in_valid && sb == 8) bovf = 1'b1;
            if (b_out_ready && sb != 0) void'(bq.pop_front());
            if (b_in_valid && sb != 8) bq.push_back(b_in_data);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a();
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_data = 32'h0;
    endtask

    task automatic flush_a();
        idle_a();
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        #12;
        total++; if (a_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", a_count); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", a_in_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", a_out_valid); end
        total++; if (a_out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%08h exp=00000000", a_out_data); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b exp=0", a_ovf); end
        total++; if (b_count !== 4'd0 || b_in_ready !== 1'b1) begin bad++; $display("FAIL rst_b got=%0d/%0b exp=0/1", b_count, b_in_ready); end
        CLR = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill();
        idle_a();
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = w[i];
            step();
            if (i == 0) begin
                total++; if (a_out_valid !== 1'b1 || a_out_data !== w[0]) begin bad++; $display("FAIL fill_latency got=%0b/%08h exp=1/%08h", a_out_valid, a_out_data, w[0]); end
            end
        end
        a_in_valid = 1'b0;
        total++; if (a_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", a_count); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b exp=0", a_in_ready); end
        total++; if (a_out_data !== 32'hE3A01001) begin bad++; $display("FAIL fill_head got=%08h exp=E3A01001", a_out_data); end
    endtask

    task automatic test_drain();
        idle_a();
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (a_out_data !== w[i]) begin bad++; $display("FAIL drain_data[%0d] got=%08h exp=%08h", i, a_out_data, w[i]); end
            step();
        end
        a_out_ready = 1'b0;
        total++; if (a_count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", a_count); end
        total++; if (a_out_data !== 32'h0 || a_out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%08h/%0b exp=0/0", a_out_data, a_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        idle_a();
        a_in_valid = 1'b1; a_in_data = 32'h00000001; step();
        a_in_data = 32'h00000002; step();
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'h11111111; a_out_ready = 1'b1;
            exp = (i == 0) ? 32'h00000001 : ((i == 1) ? 32'h00000002 : 32'h11111111);
            total++; if (a_out_data !== exp) begin bad++; $display("FAIL b2b_data[%0d] got=%08h exp=%08h", i, a_out_data, exp); end
            step();
            total++; if (a_count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, a_count); end
        end
        idle_a();
        total++; if (a_out_data !== 32'h11111111) begin bad++; $display("FAIL b2b_tail got=%08h exp=11111111", a_out_data); end
        flush_a();
    endtask

    task automatic test_overflow();
        idle_a();
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_data = w[i]; step();
        end
        a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        // full + pop: push must be rejected, so the queue drops to three entries
        total++; if (a_count !== 3'd3 || a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_popfull got=%0d/%0b exp=3/1", a_count, a_ovf); end
        a_in_data = 32'h0BADF00D; step();
        a_in_data = 32'hDEADBEEF; step();
        a_in_valid = 1'b0;
        total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", a_ovf); end
        total++; if (a_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", a_count); end
        total++; if (a_out_data !== w[1]) begin bad++; $display("FAIL ovf_head got=%08h exp=%08h", a_out_data, w[1]); end
        step();
        total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", a_ovf); end
        a_flush = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_data = 32'h12345678;
        step();
        idle_a();
        total++; if (a_count !== 3'd0 || a_ovf !== 1'b0 || a_out_valid !== 1'b0) begin bad++; $display("FAIL ovf_flush got=%0d/%0b/%0b exp=0/0/0", a_count, a_ovf, a_out_valid); end
    endtask

    task automatic test_async_reset();
        idle_a();
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = $urandom(); step();
        end
        a_out_ready = 1'b1;
        #2;
        CLR = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin bad++; $display("FAIL areset_now got=%0b/%0d exp=0/0", a_out_valid, a_count); end
        total++; if (a_in_ready !== 1'b1 || a_out_data !== 32'h0) begin bad++; $display("FAIL areset_out got=%0b/%08h exp=1/0", a_in_ready, a_out_data); end
        mq.delete(); movf = 1'b0;
        bq.delete(); bovf = 1'b0;
        @(posedge CLK);
        #1;
        total++; if (a_count !== 3'd0) begin bad++; $display("FAIL areset_hold got=%0d exp=0", a_count); end
        CLR = 1'b1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h0000000A;
        step();
        a_in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h0000000A) begin bad++; $display("FAIL areset_push got=%0b/%08h exp=1/0000000A", a_out_valid, a_out_data); end
        flush_a();
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        for (int c = 0; c < 400; c++) begin
            a_in_valid  = ($urandom_range(0, 9) < 6);
            a_out_ready = ($urandom_range(0, 9) < 4);
            a_flush     = ($urandom_range(0, 49) == 0);
            a_in_data   = $urandom();
            step();
            exp_d = (mq.size() != 0) ? mq[0] : 32'h0;
            total++; if (a_count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, a_count, mq.size()); end
            total++; if (a_out_data !== exp_d) begin bad++; $display("FAIL rnd_data cyc=%0d got=%08h exp=%08h", c, a_out_data, exp_d); end
            total++; if (a_out_valid !== (mq.size() != 0) || a_in_ready !== (mq.size() != 4)) begin bad++; $display("FAIL rnd_hs cyc=%0d got=%0b/%0b size=%0d", c, a_out_valid, a_in_ready, mq.size()); end
            total++; if (a_ovf !== movf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", c, a_ovf, movf); end
        end
        idle_a();
    endtask

    task automatic test_depth8();
        logic [15:0] bw [8];
        b_out_ready = 1'b0; b_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bw[i] = 16'($urandom());
            total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL d8_ready_fill[%0d] got=%0b exp=1", i, b_in_ready); end
            b_in_valid = 1'b1; b_in_data = bw[i];
            step();
            total++; if (b_count !== 4'(i + 1)) begin bad++; $display("FAIL d8_count[%0d] got=%0d exp=%0d", i, b_count, i + 1); end
        end
        b_in_valid = 1'b0;
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL d8_full got=%0b exp=0", b_in_ready); end
        b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (b_out_data !== bw[i]) begin bad++; $display("FAIL d8_order[%0d] got=%04h exp=%04h", i, b_out_data, bw[i]); end
            total++; if (b_in_ready !== (i != 0)) begin bad++; $display("FAIL d8_ready_drain[%0d] got=%0b", i, b_in_ready); end
            step();
        end
        b_out_ready = 1'b0;
        total++; if (b_count !== 4'd0 || b_out_valid !== 1'b0 || b_out_data !== 16'h0) begin bad++; $display("FAIL d8_empty got=%0d/%0b/%04h exp=0/0/0", b_count, b_out_valid, b_out_data); end
        total++; if (bq.size() != 0 || b_ovf !== 1'b0) begin bad++; $display("FAIL d8_model got=%0d/%0b exp=0/0", bq.size(), b_ovf); end
    endtask

    initial begin
        w[0] = 32'hE3A01001; w[1] = 32'hE3A02002; w[2] = 32'hE0813002; w[3] = 32'hEAFFFFFE;
        movf = 1'b0; bovf = 1'b0;
        idle_a();
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_in_data = 16'h0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        test_random();
        test_depth8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries; legal values are powers of two, 2 to 64.
REQ-003 Parameter CNT_W, default 3, SHALL set the count width and equal log2(DEPTH)+1.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 CLR  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mean the fetch side presents a word.
REQ-007 in_data  input  DATA_W  SHALL carry the fetched instruction word.
REQ-008 in_ready  output  1  SHALL mean the queue accepts a word this cycle.
REQ-009 out_valid  output  1  SHALL mean a word is available to the instruction register.
REQ-010 out_data  output  DATA_W  SHALL carry the oldest stored word.
REQ-011 out_ready  input  1  SHALL mean the consumer takes out_data this cycle.
REQ-012 flush  input  1  SHALL discard all contents on a taken branch.
REQ-013 count  output  CNT_W  SHALL report the number of stored words.
REQ-014 ovf  output  1  SHALL be a sticky flag recording a dropped word.

Function
REQ-015 Push SHALL occur when in_valid=1 and in_ready=1 at a rising edge; in_data is written at the tail.
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1 at a rising edge; the head advances.
REQ-017 in_ready SHALL equal (count != DEPTH), decoded combinationally from registered state.
REQ-018 out_valid SHALL equal (count != 0), decoded combinationally from registered state.
REQ-019 out_data SHALL present the head entry combinationally (first-word fall-through), and SHALL be all zeros when out_valid=0.
REQ-020 Latency SHALL be exactly 1 cycle: a word pushed into an empty queue at edge N appears with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-021 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged, and both pointers SHALL advance.
REQ-022 When full, in_ready=0, so a simultaneous pop SHALL NOT admit a push in the same cycle.
REQ-023 Head and tail pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH without a gap.
REQ-024 If in_valid=1 while count=DEPTH, the word SHALL be dropped and ovf SHALL set to 1 at that edge.
REQ-025 ovf SHALL stay 1 until reset or flush.
REQ-026 flush=1 at an edge SHALL set count=0, head=0, tail=0 and ovf=0.
REQ-027 Flush SHALL take priority over any push or pop in the same cycle; that push is discarded and that pop has no effect.
REQ-028 Storage contents SHALL need no clearing on flush; stale entries SHALL never be visible, per REQ-019.
REQ-029 count SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-030 When CLR=0, the following SHALL hold immediately, independent of CLK: count=0, head=0, tail=0, ovf=0, out_valid=0, out_data=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL abandon all stored words; an in-progress push or pop SHALL have no effect.
REQ-032 After CLR returns to 1, the first push SHALL be accepted at the first rising edge.

Verification
REQ-033 With DEPTH=4, push 0xE3A01001, 0xE3A02002, 0xE0813002 and 0xEAFFFFFE on consecutive cycles with out_ready=0 -> count=4, in_ready=0, out_data=0xE3A01001.
REQ-034 From full, hold out_ready=1 for 4 cycles -> out_data sequence 0xE3A01001, 0xE3A02002, 0xE0813002, 0xEAFFFFFE, then count=0 and out_data=0.
REQ-035 With count=2, apply push 0x11111111 and pop in the same cycle -> count stays 2; after 6 such cycles the pointers have wrapped and FIFO order is preserved.
REQ-036 From full, apply in_valid=1 with 0xDEADBEEF -> the word is dropped, ovf=1, count=4; then flush=1 with in_valid=1 -> count=0, ovf=0, out_valid=0.
REQ-037 With count=3, pull CLR low between clock edges -> out_valid=0 and count=0 immediately; after release, push 0x0000000A -> out_data=0x0000000A after 1 edge.
REQ-038 With DEPTH=8 and DATA_W=16, fill with 8 words, then drain fully -> in_ready falls only at count=8, and order is preserved.
